// File: rtl/board_state_writer.sv
// rtl/board_state_writer.sv - tic-tac-toe board register with move legality, win/draw detection and turn FSM
// Optional player-turn forfeit timeout is built only when PLYR_TIMEOUT_EN is defined.
module board_state_writer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       plyr_valid,
  input  logic [8:0] plyr,
  input  logic       comp_valid,
  input  logic [8:0] comp,
  output logic [1:0] p1,
  output logic [1:0] p2,
  output logic [1:0] p3,
  output logic [1:0] p4,
  output logic [1:0] p5,
  output logic [1:0] p6,
  output logic [1:0] p7,
  output logic [1:0] p8,
  output logic [1:0] p9,
  output logic       accept,
  output logic       illegal,
  output logic       turn,
  output logic [1:0] winner,
  output logic       done,
  output logic [3:0] move_cnt
);

  typedef enum logic [1:0] {PLYR = 2'd0, COMP = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [8:0][1:0] board_q, board_d, board_mv;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      winner_q, winner_d;
  logic            accept_q, accept_d;
  logic            illegal_q, illegal_d;

  logic            mv_req, one_hot, legal, line_hit;
  logic [8:0]      mv_vec, occupied, mover_bits;
  logic [1:0]      mark;

`ifdef PLYR_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  function automatic logic has_line(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Decode the current-turn request and evaluate lines on the board as it would be after the move
  always_comb begin
    mv_req  = ((state_q == PLYR) && plyr_valid) || ((state_q == COMP) && comp_valid);
    mv_vec  = (state_q == COMP) ? comp : plyr;
    mark    = (state_q == COMP) ? 2'b10 : 2'b01;
    one_hot = (mv_vec != 9'd0) && ((mv_vec & (mv_vec - 9'd1)) == 9'd0);
    for (int i = 0; i < 9; i++) begin
      occupied[i]   = (board_q[i] != 2'b00);
      board_mv[i]   = mv_vec[i] ? mark : board_q[i];
      mover_bits[i] = (board_mv[i] == mark);
    end
    legal    = one_hot && ((mv_vec & occupied) == 9'd0);
    line_hit = has_line(mover_bits);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PLYR;
      board_q   <= '0;
      cnt_q     <= 4'd0;
      winner_q  <= 2'b00;
      accept_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef PLYR_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      accept_q  <= accept_d;
      illegal_q <= illegal_d;
`ifdef PLYR_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    accept_d  = 1'b0;
    illegal_d = 1'b0;
    if (new_game) begin
      state_d  = PLYR;
      board_d  = '0;
      cnt_d    = 4'd0;
      winner_d = 2'b00;
    end else if (mv_req) begin
      if (legal) begin
        board_d  = board_mv;
        cnt_d    = cnt_q + 4'd1;
        accept_d = 1'b1;
        if (line_hit) begin
          winner_d = mark;
          state_d  = DONE;
        end else if (cnt_q == 4'd8) begin
          winner_d = 2'b11;
          state_d  = DONE;
        end else begin
          state_d = (state_q == PLYR) ? COMP : PLYR;
        end
      end else begin
        illegal_d = 1'b1;
      end
    end
`ifdef PLYR_TIMEOUT_EN
    tmo_d = '0;
    if (!new_game && (state_q == PLYR) && !accept_d) begin
      if (tmo_q == TMO_LAST) begin
        winner_d = 2'b10;
        state_d  = DONE;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif
  end

  always_comb begin
    p1       = board_q[0];
    p2       = board_q[1];
    p3       = board_q[2];
    p4       = board_q[3];
    p5       = board_q[4];
    p6       = board_q[5];
    p7       = board_q[6];
    p8       = board_q[7];
    p9       = board_q[8];
    accept   = accept_q;
    illegal  = illegal_q;
    turn     = (state_q == COMP);
    winner   = winner_q;
    done     = (state_q == DONE);
    move_cnt = cnt_q;
  end

endmodule

// File: tb/tb_board_state_writer.sv
// tb/tb_board_state_writer.sv - scoreboard bench for board_state_writer with an array-based game model
// Timeout expectations follow PLYR_TIMEOUT_EN with TIMEOUT_CYCLES = 8.
module tb_board_state_writer;

  localparam int TMO = 8;

  logic       clock, reset_n, new_game, plyr_valid, comp_valid;
  logic [8:0] plyr, comp;
  logic [1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9, winner;
  logic       accept, illegal, turn, done;
  logic [3:0] move_cnt;

  board_state_writer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .new_game(new_game),
    .plyr_valid(plyr_valid), .plyr(plyr), .comp_valid(comp_valid), .comp(comp),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .accept(accept), .illegal(illegal), .turn(turn), .winner(winner), .done(done),
    .move_cnt(move_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [17:0] board;
    logic        accept;
    logic        illegal;
    logic        turn;
    logic [1:0]  winner;
    logic        done;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Game model: cells hold 0 empty, 1 player, 2 computer
  int b [9];
  int m_turn, m_cnt, m_win, m_idle;
  bit m_done;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit wins(int who);
    for (int l = 0; l < 8; l++)
      if (b[lines[l][0]] == who && b[lines[l][1]] == who && b[lines[l][2]] == who) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) b[i] = 0;
    m_turn = 0; m_cnt = 0; m_win = 0; m_idle = 0; m_done = 1'b0;
  endtask

  function automatic logic [17:0] dut_board();
    return {p9, p8, p7, p6, p5, p4, p3, p2, p1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  // Drive one cycle of inputs now and queue the response the model predicts for the next edge
  task automatic apply(input bit ng, input bit pv, input logic [8:0] pvec, input bit cv, input logic [8:0] cvec);
    exp_t e;
    bit acc, ill, was_plyr;
    logic [8:0] vec;
    int pos;
    new_game = ng; plyr_valid = pv; plyr = pvec; comp_valid = cv; comp = cvec;
    acc = 1'b0; ill = 1'b0;
    was_plyr = !m_done && (m_turn == 0);
    if (ng) begin
      model_clear();
    end else if (!m_done && ((m_turn == 0 && pv) || (m_turn == 1 && cv))) begin
      vec = (m_turn == 1) ? cvec : pvec;
      pos = -1;
      if ($countones(vec) == 1)
        for (int i = 0; i < 9; i++) if (vec[i]) pos = i;
      if (pos >= 0 && b[pos] == 0) begin
        b[pos] = (m_turn == 1) ? 2 : 1;
        m_cnt++;
        acc = 1'b1;
        if (wins(b[pos])) begin m_win = b[pos]; m_done = 1'b1; end
        else if (m_cnt == 9) begin m_win = 3; m_done = 1'b1; end
        else m_turn = 1 - m_turn;
      end else begin
        ill = 1'b1;
      end
    end
`ifdef PLYR_TIMEOUT_EN
    if (ng || !was_plyr || acc) m_idle = 0;
    else if (m_idle == TMO - 1) begin m_idle = 0; m_win = 2; m_done = 1'b1; end
    else m_idle++;
`endif
    for (int i = 0; i < 9; i++) e.board[2*i +: 2] = 2'(b[i]);
    e.accept = acc; e.illegal = ill;
    e.turn = m_done ? 1'b0 : 1'(m_turn);
    e.winner = 2'(m_win); e.done = m_done; e.cnt = 4'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit ng, input bit pv, input logic [8:0] pvec, input bit cv, input logic [8:0] cvec);
    @(negedge clock);
    apply(ng, pv, pvec, cv, cvec);
  endtask

  task automatic pmove(input int pos);
    drive(1'b0, 1'b1, 9'(1 << (pos - 1)), 1'b0, 9'd0);
  endtask

  task automatic cmove(input int pos);
    drive(1'b0, 1'b0, 9'd0, 1'b1, 9'(1 << (pos - 1)));
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [8:0] rand_vec();
    logic [8:0] v;
    if ($urandom_range(0, 3) != 0) v = 9'd1 << $urandom_range(0, 8);
    else v = 9'($urandom);
    return v;
  endfunction

  // Monitor: compare each registered response against the oldest queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_board() !== e.board) begin
          errors++;
          $display("FAIL board actual=%h expected=%h", dut_board(), e.board);
        end
        checks++;
        if ({accept, illegal, turn, winner, done, move_cnt} !== {e.accept, e.illegal, e.turn, e.winner, e.done, e.cnt}) begin
          errors++;
          $display("FAIL status acc/ill/turn/win/done/cnt actual=%b %b %b %b %b %0d expected=%b %b %b %b %b %0d",
                   accept, illegal, turn, winner, done, move_cnt,
                   e.accept, e.illegal, e.turn, e.winner, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; new_game = 1'b0; plyr_valid = 1'b0; comp_valid = 1'b0; plyr = '0; comp = '0;
    model_clear();
    #1;
    check("reset_outputs", {dut_board(), accept, illegal, turn, winner, done, move_cnt}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    apply(1'b0, 1'b1, 9'h001, 1'b0, 9'd0);
    settle();
    check("first_move_after_reset_p1", 32'(p1), 32'd1);

    drive(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    pmove(1);
    settle();
    check("req030_p1", 32'(p1), 32'd1);
    check("req030_turn", 32'(turn), 32'd1);
    cmove(1);
    settle();
    check("req030_illegal", 32'(illegal), 32'd1);
    check("req030_turn_hold", 32'(turn), 32'd1);

    drive(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    drive(1'b0, 1'b1, 9'h003, 1'b0, 9'd0);
    settle();
    check("req031_illegal", 32'(illegal), 32'd1);
    check("req031_cnt", 32'(move_cnt), 32'd0);
    drive(1'b0, 1'b1, 9'h010, 1'b1, 9'h020);
    drive(1'b0, 1'b1, 9'h001, 1'b0, 9'd0);

    drive(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    pmove(1); cmove(4); pmove(2); cmove(5); pmove(3);
    settle();
    check("req032_winner", 32'(winner), 32'd1);
    check("req032_done", 32'(done), 32'd1);
    check("req032_cnt", 32'(move_cnt), 32'd5);

    drive(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    pmove(1); cmove(2); pmove(3); cmove(5); pmove(4); cmove(6); pmove(8); cmove(7); pmove(9);
    settle();
    check("req033_winner", 32'(winner), 32'd3);
    check("req033_cnt", 32'(move_cnt), 32'd9);
    drive(1'b0, 1'b1, 9'h002, 1'b1, 9'h002);
    settle();
    check("req033_no_pulse", {30'd0, accept, illegal}, 32'd0);

    drive(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    pmove(5); cmove(1);
    drive(1'b1, 1'b1, 9'h004, 1'b0, 9'd0);
    settle();
    check("req034_newgame_clear", {dut_board(), accept, turn, move_cnt}, 32'd0);
    pmove(5); cmove(1);
    settle();
    reset_n = 1'b0;
    #1;
    check("req034_async_reset", {dut_board(), accept, illegal, turn, winner, done, move_cnt}, 32'd0);
    model_clear();
    @(negedge clock);
    plyr_valid = 1'b1; plyr = 9'h001;
    @(posedge clock);
    #1;
    check("inputs_ignored_in_reset", {dut_board(), accept, move_cnt}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    apply(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);

    drive(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
    repeat (100) drive(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);
    settle();
`ifdef PLYR_TIMEOUT_EN
    check("req035_timeout_winner", {30'd0, winner}, 32'd2);
    check("req035_timeout_done", 32'(done), 32'd1);
`else
    check("req035_no_timeout", 32'(done), 32'd0);
`endif

    for (int n = 0; n < 1500; n++)
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, rand_vec(),
            $urandom_range(0, 2) != 0, rand_vec());
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
